// File: rtl/ebpf_shift_pkg.sv
// Shared types and constants for the eBPF shift arbiter slice.
package ebpf_shift_pkg;

   localparam int unsigned SH_DATA_W = 64;
   // Tag width carried in the request payload; the top-level TAG_W must equal this.
   localparam int unsigned SH_TAG_W  = 4;

   localparam logic [5:0] SH_MASK64 = 6'h3F;
   localparam logic [4:0] SH_MASK32 = 5'h1F;

   typedef enum logic [1:0] {
      SH_LSH  = 2'd0,
      SH_RSH  = 2'd1,
      SH_ARSH = 2'd2,
      SH_RSVD = 2'd3
   } shift_op_e;

   typedef struct packed {
      shift_op_e             op;
      logic                  is32;
      logic [SH_DATA_W-1:0]  a;
      logic [SH_DATA_W-1:0]  b;
      logic [SH_TAG_W-1:0]   tag;
   } shift_req_t;

endpackage

// File: rtl/ebpf_shift_unit.sv
// Combinational eBPF shift: amount masking, ALU32 zero-extension, reserved-op error.
module ebpf_shift_unit
   import ebpf_shift_pkg::*;
(
   input  shift_op_e              op,
   input  logic                   is32,
   input  logic [SH_DATA_W-1:0]   a,
   input  logic [SH_DATA_W-1:0]   b,
   output logic [SH_DATA_W-1:0]   data,
   output logic                   err
);

   logic [5:0]            sh64;
   logic [4:0]            sh32;
   logic [31:0]           a32;
   logic [31:0]           r32;
   logic [SH_DATA_W-1:0]  r64;

   // Only the low shift-amount bits are architecturally meaningful.
   logic unused_b;
   assign unused_b = ^b[SH_DATA_W-1:6];

   // Compute both widths, then select; reserved op forces zero data.
   always_comb begin
      sh64 = b[5:0] & SH_MASK64;
      sh32 = b[4:0] & SH_MASK32;
      a32  = a[31:0];
      r32  = '0;
      r64  = '0;
      err  = 1'b0;
      case (op)
         SH_LSH: begin
            r64 = a << sh64;
            r32 = a32 << sh32;
         end
         SH_RSH: begin
            r64 = a >> sh64;
            r32 = a32 >> sh32;
         end
         SH_ARSH: begin
            r64 = $signed(a) >>> sh64;
            r32 = $signed(a32) >>> sh32;
         end
         default: err = 1'b1;
      endcase
      if (err)
         data = '0;
      else if (is32)
         data = {32'h0, r32};
      else
         data = r64;
   end

endmodule

// File: rtl/ebpf_shift_arbiter.sv
// Round-robin arbiter sharing one eBPF shift datapath, with a registered valid/ready response.
module ebpf_shift_arbiter
   import ebpf_shift_pkg::*;
#(
   parameter int unsigned NREQ  = 2,
   parameter int unsigned TAG_W = 4,
   parameter int unsigned CNT_W = 32
)(
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NREQ-1:0]           req_valid,
   output logic [NREQ-1:0]           req_ready,
   input  logic [NREQ*2-1:0]         req_op,
   input  logic [NREQ-1:0]           req_is32,
   input  logic [NREQ*64-1:0]        req_a,
   input  logic [NREQ*64-1:0]        req_b,
   input  logic [NREQ*TAG_W-1:0]     req_tag,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [63:0]               rsp_data,
   output logic [TAG_W-1:0]          rsp_tag,
   output logic [$clog2(NREQ)-1:0]   rsp_src,
   output logic                      rsp_err,
   output logic [CNT_W-1:0]          op_count
);

   localparam int unsigned SRC_W = $clog2(NREQ);

   shift_req_t              reqs [NREQ];
   shift_req_t              sel;
   logic                    out_free;
   logic                    grant_any;
   logic [SRC_W-1:0]        grant_idx;
   logic [SRC_W-1:0]        cand;
   logic [SRC_W-1:0]        rr_last;
   logic [SH_DATA_W-1:0]    unit_data;
   logic                    unit_err;

   // Unpack the flat request ports into payload structs.
   always_comb begin
      for (int i = 0; i < int'(NREQ); i++) begin
         reqs[i].op   = shift_op_e'(req_op[i*2 +: 2]);
         reqs[i].is32 = req_is32[i];
         reqs[i].a    = req_a[i*64 +: 64];
         reqs[i].b    = req_b[i*64 +: 64];
         reqs[i].tag  = SH_TAG_W'(req_tag[i*TAG_W +: TAG_W]);
      end
   end

   // Round-robin scan starting after the last grantee; grant only when the output slot frees.
   always_comb begin
      out_free  = !rsp_valid || rsp_ready;
      grant_any = 1'b0;
      grant_idx = '0;
      cand      = '0;
      for (int k = 1; k <= int'(NREQ); k++) begin
         cand = SRC_W'((int'(rr_last) + k) % int'(NREQ));
         if (!grant_any && req_valid[cand]) begin
            grant_any = 1'b1;
            grant_idx = cand;
         end
      end
      if (!out_free || !rst_n)
         grant_any = 1'b0;
   end

   // One-hot ready on the grantee.
   always_comb begin
      req_ready = '0;
      if (grant_any)
         req_ready[grant_idx] = 1'b1;
   end

   // Route the granted payload to the shared datapath.
   always_comb begin
      sel = reqs[grant_idx];
   end

   ebpf_shift_unit u_shift (
      .op   (sel.op),
      .is32 (sel.is32),
      .a    (sel.a),
      .b    (sel.b),
      .data (unit_data),
      .err  (unit_err)
   );

   // Output register and round-robin pointer: load on grant, drain on handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         rsp_tag   <= '0;
         rsp_src   <= '0;
         rsp_err   <= 1'b0;
         rr_last   <= SRC_W'(NREQ - 1);
      end else if (grant_any) begin
         rsp_valid <= 1'b1;
         rsp_data  <= unit_data;
         rsp_tag   <= TAG_W'(sel.tag);
         rsp_src   <= grant_idx;
         rsp_err   <= unit_err;
         rr_last   <= grant_idx;
      end else if (rsp_ready) begin
         rsp_valid <= 1'b0;
      end
   end

   // Saturating count of completed response handshakes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         op_count <= '0;
      else if (rsp_valid && rsp_ready && (op_count != {CNT_W{1'b1}}))
         op_count <= op_count + CNT_W'(1);
   end

endmodule
